// File: rtl/router_pkg.sv
// router_pkg: shared state encodings and address constants for the 1x3 router
package router_pkg;

    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Selects one of the three per-FIFO flags; the invalid address selects nothing.
    function automatic logic pick(input logic [2:0] v, input logic [ADDR_W-1:0] a);
        return (a == 2'd0) ? v[0] : (a == 2'd1) ? v[1] : (a == 2'd2) ? v[2] : 1'b0;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: control signals between the router FSM and its neighbours
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] din;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;

    modport master (
        output pkt_valid, din, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, din, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        output detect_addr, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// router_fsm: Moore packet-control FSM of the 1x3 router (decode, load, full handling, parity)
module router_fsm
    import router_pkg::*;
(
    input logic        clk,
    input logic        rst,
    router_fsm_if.slave bus
);

    state_t            state, next;
    logic [ADDR_W-1:0] addr_q;
    logic              hdr_ok, empty_sel, soft_sel;

    assign hdr_ok    = bus.pkt_valid && bus.din != ADDR_INVALID;
    assign empty_sel = pick({bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0},
                            state == DECODE_ADDRESS ? bus.din : addr_q);
    // A timeout only matters once a destination has been committed to.
    assign soft_sel  = state != DECODE_ADDRESS &&
                       pick({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, addr_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= next;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_q <= bus.din;
        end
    end

    always_comb begin
        next = state;
        case (state)
            DECODE_ADDRESS:     next = hdr_ok ? (empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY) : DECODE_ADDRESS;
            LOAD_FIRST_DATA:    next = LOAD_DATA;
            LOAD_DATA:          next = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
            FIFO_FULL_STATE:    next = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    next = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    next = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            next = DECODE_ADDRESS;
        endcase
        if (soft_sel)
            next = DECODE_ADDRESS;
    end

    assign bus.detect_addr   = state == DECODE_ADDRESS;
    assign bus.lfd_state     = state == LOAD_FIRST_DATA;
    assign bus.ld_state      = state == LOAD_DATA;
    assign bus.laf_state     = state == LOAD_AFTER_FULL;
    assign bus.full_state    = state == FIFO_FULL_STATE;
    assign bus.write_enb_reg = state == LOAD_DATA || state == LOAD_PARITY || state == LOAD_AFTER_FULL;
    assign bus.rst_int_reg   = state == CHECK_PARITY_ERROR;
    assign bus.busy          = !(state == DECODE_ADDRESS || state == LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scoreboard bench for the router control FSM
module tb_router_fsm;

    // Output patterns {detect, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] DEC  = 8'b1000_0000;
    localparam logic [7:0] LFD  = 8'b0100_0001;
    localparam logic [7:0] LD   = 8'b0010_0100;
    localparam logic [7:0] LAF  = 8'b0001_0101;
    localparam logic [7:0] FULL = 8'b0000_1001;
    localparam logic [7:0] LP   = 8'b0000_0101;
    localparam logic [7:0] CPE  = 8'b0000_0011;
    localparam logic [7:0] WTE  = 8'b0000_0001;

    typedef struct {
        logic [9:0] v;
        string      name;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    logic [9:0] got;

    router_fsm_if bus();

    router_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign got = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                  bus.write_enb_reg, bus.rst_int_reg, bus.busy, dut.addr_q};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got outs=%b addr=%0d, expected outs=%b addr=%0d",
                         e.name, got[9:2], got[1:0], e.v[9:2], e.v[1:0]);
            end
        end
    end

    task automatic step(input logic [7:0] o, input logic [1:0] a, input string n);
        @(posedge clk);
        #1;
        q.push_back('{{o, a}, n});
    endtask

    initial begin
        bus.pkt_valid     = 1'b0;
        bus.din           = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        step(DEC, 2'd0, "reset0");
        step(DEC, 2'd0, "reset1");
        rst = 1'b1;

        bus.din = 2'd1; bus.pkt_valid = 1'b1;
        step(LFD, 2'd1, "norm_lfd");
        for (int i = 0; i < 4; i++) step(LD, 2'd1, "norm_ld");
        bus.pkt_valid = 1'b0;
        step(LP, 2'd1, "norm_lp");
        step(CPE, 2'd1, "norm_cpe");
        step(DEC, 2'd1, "norm_dec");

        bus.din = 2'd0; bus.pkt_valid = 1'b1;
        step(LFD, 2'd0, "full_lfd");
        step(LD, 2'd0, "full_ld");
        bus.fifo_full = 1'b1;
        step(FULL, 2'd0, "full_enter");
        step(FULL, 2'd0, "full_hold");
        bus.fifo_full = 1'b0;
        step(LAF, 2'd0, "full_laf");
        step(LD, 2'd0, "laf_to_ld");
        bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
        step(FULL, 2'd0, "full_prio");
        bus.fifo_full = 1'b0;
        step(LAF, 2'd0, "full_laf2");
        bus.low_pkt_valid = 1'b1;
        step(LP, 2'd0, "laf_to_lp");
        bus.low_pkt_valid = 1'b0; bus.fifo_full = 1'b1;
        step(CPE, 2'd0, "lp_to_cpe");
        step(FULL, 2'd0, "cpe_to_full");
        bus.fifo_full = 1'b0;
        step(LAF, 2'd0, "full_laf3");
        bus.parity_done = 1'b1;
        step(DEC, 2'd0, "laf_to_dec");
        bus.parity_done = 1'b0;

        bus.din = 2'd2; bus.fifo_empty_2 = 1'b0; bus.pkt_valid = 1'b1;
        step(WTE, 2'd2, "wait_enter");
        bus.din = 2'd0;
        step(WTE, 2'd2, "wait_hold");
        bus.fifo_empty_2 = 1'b1;
        step(LFD, 2'd2, "wait_lfd");
        step(LD, 2'd2, "wait_ld");
        bus.pkt_valid = 1'b0;
        step(LP, 2'd2, "wait_lp");
        step(CPE, 2'd2, "wait_cpe");
        step(DEC, 2'd2, "wait_dec");

        bus.din = 2'd3; bus.pkt_valid = 1'b1;
        step(DEC, 2'd2, "inval0");
        step(DEC, 2'd2, "inval1");

        bus.din = 2'd2; bus.fifo_empty_2 = 1'b0;
        step(WTE, 2'd2, "to_wait");
        bus.soft_reset_0 = 1'b1;
        step(WTE, 2'd2, "sr_other");
        bus.soft_reset_0 = 1'b0; bus.soft_reset_2 = 1'b1;
        step(DEC, 2'd2, "sr_hit");
        bus.pkt_valid = 1'b0;
        step(DEC, 2'd2, "sr_in_dec");
        bus.fifo_empty_2 = 1'b1;
        bus.din = 2'd1; bus.pkt_valid = 1'b1;
        step(LFD, 2'd1, "sr_unaddr_lfd");
        bus.soft_reset_2 = 1'b0;
        step(LD, 2'd1, "sr_ld");
        bus.soft_reset_1 = 1'b1;
        step(DEC, 2'd1, "sr_mid_pkt");
        bus.soft_reset_1 = 1'b0;

        step(LFD, 2'd1, "pre_rst_lfd");
        rst = 1'b0;
        step(DEC, 2'd0, "rst_mid_pkt");
        rst = 1'b1; bus.pkt_valid = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
